uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_select.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encoding, activation-timeout default,
// and the transmitter's own state constants.
package uart_pkg;
    typedef enum logic [2:0] {
        ARB       = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_ACT  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } arb_state_t;

    localparam int ACT_TIMEOUT_DEF = 7;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_START   = 3'd1,
        TX_DATA    = 3'd2,
        TX_STOP    = 3'd3,
        TX_CLEANUP = 3'd4
    } tx_state_t;
endpackage

// File: rtl/rr_select.sv
// Round-robin selector: first set req bit at or after ptr, wrapping modulo N.
module rr_select #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] index
);
    logic          found;
    int            k;
    logic [IW-1:0] kk;

    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        k      = 0;
        kk     = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            kk = k[IW-1:0];
            if (!found && req[kk]) begin
                found      = 1'b1;
                onehot[kk] = 1'b1;
                index      = kk;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one byte at a time from NUM_REQ requesters into a
// UART transmitter, with an activation timeout and a done-deglitch gap state.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACT_TIMEOUT = uart_pkg::ACT_TIMEOUT_DEF
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_Busy,
    output logic                   o_Err,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done
);
    import uart_pkg::*;

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACT_TIMEOUT + 1);

    logic [NUM_REQ-1:0][7:0] req_bytes;
    arb_state_t              state, state_nxt;
    logic [IW-1:0]           rr_ptr;
    logic [CW-1:0]           act_cnt;
    logic [7:0]              tx_byte;
    logic [NUM_REQ-1:0]      sel_onehot;
    logic [IW-1:0]           sel_idx;
    logic                    grant_fire;
    logic                    act_expired;

    assign req_bytes   = i_Req_Byte;
    assign act_expired = (act_cnt == CW'(ACT_TIMEOUT));

    rr_select #(.N(NUM_REQ), .IW(IW)) u_sel (
        .req   (i_Req),
        .ptr   (rr_ptr),
        .onehot(sel_onehot),
        .index (sel_idx)
    );

    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        o_Tx_DV    = 1'b0;
        o_Err      = 1'b0;
        case (state)
            ARB:       if (|i_Req) begin
                           grant_fire = 1'b1;
                           state_nxt  = LAUNCH;
                       end
            LAUNCH:    begin
                           o_Tx_DV   = 1'b1;
                           state_nxt = WAIT_ACT;
                       end
            WAIT_ACT:  if (i_Tx_Active) state_nxt = WAIT_DONE;
                       else if (act_expired) begin
                           o_Err     = 1'b1;
                           state_nxt = ARB;
                       end
            WAIT_DONE: if (i_Tx_Done) state_nxt = GAP;
            // done is two cycles wide; wait for it to drop so it counts once
            GAP:       if (!i_Tx_Done) state_nxt = ARB;
            default:   state_nxt = ARB;
        endcase
        // reset wins over anything the current state would emit
        if (i_Reset) begin
            grant_fire = 1'b0;
            o_Tx_DV    = 1'b0;
            o_Err      = 1'b0;
        end
    end

    assign o_Grant   = grant_fire ? sel_onehot : '0;
    assign o_Busy    = (state != ARB);
    assign o_Tx_Byte = tx_byte;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state   <= ARB;
            rr_ptr  <= '0;
            tx_byte <= 8'h00;
            act_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant_fire) begin
                tx_byte <= req_bytes[sel_idx];
                rr_ptr  <= (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
            end
            if (state == LAUNCH)
                act_cnt <= '0;
            else if (state == WAIT_ACT && !act_expired)
                act_cnt <= act_cnt + 1'b1;
        end
    end
endmodule
